// File: rtl/rain_pkg.sv
// Shared types and default constants for the rain sensor front-end.
package rain_pkg;

  typedef enum logic [1:0] {
    ST_DRY      = 2'b00,
    ST_WET_PEND = 2'b01,
    ST_DRY_PEND = 2'b10,
    ST_WET      = 2'b11
  } rain_state_e;

  localparam int unsigned DEF_CLK_DIV     = 1000;
  localparam int unsigned DEF_WET_CONFIRM = 8;
  localparam int unsigned DEF_DRY_CONFIRM = 32;
  localparam int unsigned DEF_EVT_W       = 16;

endpackage

// File: rtl/rain_tick_gen.sv
// Sample-tick prescaler: one tick every CLK_DIV clocks while enabled.
module rain_tick_gen
  import rain_pkg::*;
#(
  parameter  int unsigned CLK_DIV = DEF_CLK_DIV,
  localparam int unsigned DIV_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  output logic             o_tick_c,
  output logic [DIV_W-1:0] o_count
);

  logic [DIV_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == DIV_W'(CLK_DIV - 1));

  // Count is parked at 0 whenever sampling is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_enable || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_W'(1);
    end
  end

  assign o_tick_c = i_enable && w_last;
  assign o_count  = r_count;

endmodule

// File: rtl/rain_sensor_frontend.sv
// Debounced rain level with start/stop pulses and a saturating event count.
// Optional stuck-wet fault detection is built when RAIN_FAULT_DET_EN is defined.
module rain_sensor_frontend
  import rain_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned WET_CONFIRM   = DEF_WET_CONFIRM,
  parameter int unsigned DRY_CONFIRM   = DEF_DRY_CONFIRM,
  parameter int unsigned EVT_W         = DEF_EVT_W
`ifdef RAIN_FAULT_DET_EN
  , parameter int unsigned FAULT_SAMPLES = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic             enable,
  input  logic             fault_clr,
  output logic             rain_sensor,
  output logic             rain_start,
  output logic             rain_stop,
  output logic [EVT_W-1:0] rain_events,
  output logic [1:0]       state,
  output logic             sensor_fault
);

  localparam int unsigned CONF_MAX = (WET_CONFIRM > DRY_CONFIRM) ? WET_CONFIRM : DRY_CONFIRM;
  localparam int unsigned CNT_W    = $clog2(CONF_MAX + 1);
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);

  logic [1:0]       r_sync;
  rain_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_start;
  logic             r_stop;
  logic [EVT_W-1:0] r_events;

  logic             w_samp;
  logic             w_tick;
  logic [DIV_W-1:0] w_div_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_fault_hold;
  logic             w_unused_div;

  rain_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (enable),
    .o_tick_c (w_tick),
    .o_count  (w_div_cnt)
  );

  assign w_unused_div = ^w_div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], sensor_raw};
  end

  assign w_samp    = r_sync[1];
  assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef RAIN_FAULT_DET_EN
  localparam int unsigned RUN_W = $clog2(FAULT_SAMPLES + 1);

  logic [RUN_W-1:0] r_run;
  logic             r_fault;
  logic             w_fault_hit;

  assign w_fault_hit = w_tick && w_samp && !fault_clr &&
                       ((r_run + RUN_W'(1)) == RUN_W'(FAULT_SAMPLES));

  // Wet-run counter saturates so a long stuck run cannot wrap and re-trigger
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= '0;
      r_fault <= 1'b0;
    end else if (fault_clr) begin
      r_run   <= '0;
      r_fault <= 1'b0;
    end else if (w_tick) begin
      if (!w_samp)                             r_run <= '0;
      else if (r_run != RUN_W'(FAULT_SAMPLES)) r_run <= r_run + RUN_W'(1);
      if (w_fault_hit) r_fault <= 1'b1;
    end
  end

  assign w_fault_hold = r_fault || w_fault_hit;
  assign sensor_fault = r_fault;
`else
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = fault_clr;
  assign w_fault_hold       = 1'b0;
  assign sensor_fault       = 1'b0;
`endif

  // Wet/dry qualification FSM with registered level, pulses and event count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_DRY;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_start  <= 1'b0;
      r_stop   <= 1'b0;
      r_events <= '0;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      if (w_fault_hold) begin
        r_state <= ST_DRY;
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (!enable) begin
        // Abandon a pending qualification without touching the level
        case (r_state)
          ST_WET_PEND: begin r_state <= ST_DRY; r_cnt <= '0; end
          ST_DRY_PEND: begin r_state <= ST_WET; r_cnt <= '0; end
          default: ;
        endcase
      end else if (w_tick) begin
        case (r_state)
          ST_DRY: begin
            if (w_samp) begin
              r_state <= ST_WET_PEND;
              r_cnt   <= CNT_W'(1);
            end
          end
          ST_WET_PEND: begin
            if (!w_samp) begin
              r_state <= ST_DRY;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_W'(WET_CONFIRM)) begin
              r_state <= ST_WET;
              r_cnt   <= '0;
              r_level <= 1'b1;
              r_start <= 1'b1;
              if (r_events != '1) r_events <= r_events + EVT_W'(1);
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_WET: begin
            if (!w_samp) begin
              r_state <= ST_DRY_PEND;
              r_cnt   <= CNT_W'(1);
            end
          end
          ST_DRY_PEND: begin
            if (w_samp) begin
              r_state <= ST_WET;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_W'(DRY_CONFIRM)) begin
              r_state <= ST_DRY;
              r_cnt   <= '0;
              r_level <= 1'b0;
              r_stop  <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_DRY;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign rain_sensor = r_level;
  assign rain_start  = r_start;
  assign rain_stop   = r_stop;
  assign rain_events = r_events;
  assign state       = r_state;

endmodule

// File: tb/tb_rain_sensor_frontend.sv
// Directed bench for rain_sensor_frontend (CLK_DIV=4, WET=3, DRY=5, EVT_W=4).
// Define RAIN_FAULT_DET_EN to exercise the stuck-wet fault path (FAULT_SAMPLES=8).
module tb_rain_sensor_frontend;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned EVT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sensor_raw;
  logic             enable;
  logic             fault_clr;
  logic             rain_sensor;
  logic             rain_start;
  logic             rain_stop;
  logic [EVT_W-1:0] rain_events;
  logic [1:0]       state;
  logic             sensor_fault;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  rain_sensor_frontend #(
    .CLK_DIV       (CLK_DIV),
    .WET_CONFIRM   (3),
    .DRY_CONFIRM   (5),
    .EVT_W         (EVT_W)
`ifdef RAIN_FAULT_DET_EN
    , .FAULT_SAMPLES (8)
`endif
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_raw   (sensor_raw),
    .enable       (enable),
    .fault_clr    (fault_clr),
    .rain_sensor  (rain_sensor),
    .rain_start   (rain_start),
    .rain_stop    (rain_stop),
    .rain_events  (rain_events),
    .state        (state),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n sample ticks; keeps the bench aligned just after a tick edge
  task automatic ticks(input int n);
    repeat (n * CLK_DIV) @(negedge clk);
  endtask

  task automatic rain_cycle();
    sensor_raw = 1'b1;
    ticks(3);
    sensor_raw = 1'b0;
    ticks(5);
  endtask

  initial begin
    rst_n      = 1'b0;
    sensor_raw = 1'b1;
    enable     = 1'b1;
    fault_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level",  32'(rain_sensor), 32'd0);
    check("reset_state",  32'(state), 32'd0);
    check("reset_events", 32'(rain_events), 32'd0);
    check("reset_fault",  32'(sensor_fault), 32'd0);
    rst_n = 1'b1;

    // Raw held wet from reset release: rise exactly on the third tick
    ticks(2);
    check("pend_state", 32'(state), 32'd1);
    repeat (3) @(negedge clk);
    check("pre_rise_level", 32'(rain_sensor), 32'd0);
    @(negedge clk);
    check("rise_level",  32'(rain_sensor), 32'd1);
    check("rise_start",  32'(rain_start), 32'd1);
    check("rise_events", 32'(rain_events), 32'd1);
    check("rise_state",  32'(state), 32'd3);
    @(negedge clk);
    check("start_1clk", 32'(rain_start), 32'd0);
    repeat (3) @(negedge clk);

    // Four dry ticks then a wet one: back to WET, no stop
    sensor_raw = 1'b0;
    ticks(4);
    check("drypend_state", 32'(state), 32'd2);
    check("drypend_level", 32'(rain_sensor), 32'd1);
    sensor_raw = 1'b1;
    ticks(1);
    check("rewet_state", 32'(state), 32'd3);
    check("rewet_nostop", 32'(rain_stop), 32'd0);
    sensor_raw = 1'b0;
    ticks(5);
    check("stop_pulse", 32'(rain_stop), 32'd1);
    check("stop_level", 32'(rain_sensor), 32'd0);
    check("stop_state", 32'(state), 32'd0);
    @(negedge clk);
    check("stop_1clk", 32'(rain_stop), 32'd0);
    repeat (3) @(negedge clk);

    // Two wet ticks then dry: no qualification; then three wet ticks qualify
    sensor_raw = 1'b1;
    ticks(2);
    sensor_raw = 1'b0;
    ticks(1);
    check("short_wet_state",  32'(state), 32'd0);
    check("short_wet_events", 32'(rain_events), 32'd1);
    check("short_wet_start",  32'(rain_start), 32'd0);
    sensor_raw = 1'b1;
    ticks(3);
    check("wet3_start",  32'(rain_start), 32'd1);
    check("wet3_events", 32'(rain_events), 32'd2);
    sensor_raw = 1'b0;
    ticks(5);
    check("back_dry", 32'(state), 32'd0);

    // Event counter saturation at 15
    repeat (12) rain_cycle();
    check("events_14", 32'(rain_events), 32'd14);
    rain_cycle();
    check("events_15", 32'(rain_events), 32'd15);
    rain_cycle();
    check("events_sat", 32'(rain_events), 32'd15);

    // Enable drop mid WET_PEND
    sensor_raw = 1'b1;
    ticks(2);
    @(negedge clk);
    check("en_pend_state", 32'(state), 32'd1);
    check("en_div_cnt", 32'(u_dut.u_tick.o_count), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_state", 32'(state), 32'd0);
    check("en_drop_cnt",   32'(u_dut.u_tick.o_count), 32'd0);
    check("en_drop_level", 32'(rain_sensor), 32'd0);
    repeat (10) @(negedge clk);
    check("en_off_hold", 32'(state), 32'd0);
    check("en_off_nostart", 32'(rain_start), 32'd0);
    enable = 1'b1;
    ticks(3);
    check("reen_state", 32'(state), 32'd3);
    check("reen_events", 32'(rain_events), 32'd15);

    // Async reset in the middle of WET
    #2 rst_n = 1'b0;
    #1;
    check("arst_level",  32'(rain_sensor), 32'd0);
    check("arst_state",  32'(state), 32'd0);
    check("arst_events", 32'(rain_events), 32'd0);
    @(negedge clk);
    check("arst_nostop", 32'(rain_stop), 32'd0);
    rst_n = 1'b1;

`ifdef RAIN_FAULT_DET_EN
    // Stuck wet probe: fault after 8 wet ticks, level forced low, no stop
    ticks(3);
    check("f_wet_state", 32'(state), 32'd3);
    ticks(4);
    check("f_prefault", 32'(sensor_fault), 32'd0);
    ticks(1);
    check("f_fault",  32'(sensor_fault), 32'd1);
    check("f_level",  32'(rain_sensor), 32'd0);
    check("f_state",  32'(state), 32'd0);
    check("f_nostop", 32'(rain_stop), 32'd0);
    ticks(2);
    check("f_hold_state", 32'(state), 32'd0);
    check("f_sticky", 32'(sensor_fault), 32'd1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("f_clear", 32'(sensor_fault), 32'd0);
    repeat (3) @(negedge clk);
    ticks(2);
    check("f_requal_pend", 32'(state), 32'd1);
    ticks(1);
    check("f_requal_wet", 32'(state), 32'd3);
    check("f_requal_level", 32'(rain_sensor), 32'd1);
`else
    // Without fault detection a long wet run keeps raining
    ticks(12);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("nf_fault", 32'(sensor_fault), 32'd0);
    check("nf_level", 32'(rain_sensor), 32'd1);
    check("nf_state", 32'(state), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rain_sensor_frontend.md
Name: rain_sensor_frontend

Overview:
Sensor-side producer of the clean `rain_sensor` level consumed by the rain alert/actuator logic (LED, buzzer, irrigation switch).
- Synchronises the raw comparator output from the field rain probe.
- Samples it on a prescaled tick and confirms wet/dry transitions with hysteresis counts.
- Emits the debounced level, start/stop event pulses and a saturating rain-event count.

Parameters:
- CLK_DIV, 1000: clocks per sample tick (≥2).
- WET_CONFIRM, 8: consecutive wet samples needed to declare rain (≥2).
- DRY_CONFIRM, 32: consecutive dry samples needed to declare rain stopped (≥2).
- EVT_W, 16: rain event counter width.
- FAULT_SAMPLES, 4096: consecutive wet samples before a stuck-sensor fault (feature only).

Ports:
- clk  in  1  single system clock
- rst_n  in  1  reset, asynchronous, active-low
- sensor_raw  in  1  raw probe comparator output, asynchronous to clk, 1 = wet
- enable  in  1  sampling enable
- fault_clr  in  1  clears sticky fault (ignored without feature)
- rain_sensor  out  1  debounced level, 1 = raining; drives the alert block
- rain_start  out  1  one-clock pulse on confirmed dry→wet
- rain_stop  out  1  one-clock pulse on confirmed wet→dry
- rain_events  out  EVT_W  count of rain_start pulses, saturating
- state  out  2  FSM state for debug
- sensor_fault  out  1  stuck-wet fault flag (0 without feature)

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM = DRY, counters 0, sync flops 0.
- Synchroniser: 2-flop chain on sensor_raw. `samp` = second flop output.
- Prescaler:
  - Counts 0..CLK_DIV-1. `tick` is high for one clock when count == CLK_DIV-1, then the count wraps to 0.
  - While enable = 0, the count is held at 0 and there is no tick.
- FSM, evaluated only on tick. Encoding: DRY = 00, WET_PEND = 01, DRY_PEND = 10, WET = 11. `cnt` is the confirm counter.
  - DRY: samp = 1 → WET_PEND, cnt = 1; else stay.
  - WET_PEND: samp = 1 → cnt+1. When cnt+1 == WET_CONFIRM → WET and pulse rain_start. samp = 0 → DRY, cnt = 0.
  - WET: samp = 0 → DRY_PEND, cnt = 1; else stay.
  - DRY_PEND: samp = 0 → cnt+1. When cnt+1 == DRY_CONFIRM → DRY and pulse rain_stop. samp = 1 → WET, cnt = 0.
- Outputs:
  - rain_sensor = 1 in WET and DRY_PEND, registered. It changes in the same cycle as rain_start/rain_stop.
  - The FSM transition, level change and pulse all occur in the clock following the confirming tick.
- Latency, raw edge to rain_sensor rise: 2 sync clocks + tick alignment (≤ CLK_DIV) + (WET_CONFIRM-1)·CLK_DIV + 1.
- rain_events increments on rain_start and holds at 2^EVT_W-1.
- enable falling mid-operation: on the next clock WET_PEND → DRY and DRY_PEND → WET, cnt = 0. No pulses are generated and rain_sensor is unchanged.
- Reset mid-pending: immediate return to DRY with rain_sensor = 0, and no rain_stop pulse.

Optional Feature:
- Macro: RAIN_FAULT_DET_EN.
- With the macro:
  - A wet-run counter increments on each tick with samp = 1 and clears on a tick with samp = 0.
  - When the counter reaches FAULT_SAMPLES, sensor_fault sets (sticky). The FSM is forced to DRY and rain_sensor is forced to 0, so irrigation is not blocked by a stuck probe. No rain_stop pulse is generated.
  - While the fault is set, the FSM is held in DRY.
  - fault_clr = 1 clears the fault and the run counter on the next clock. fault_clr takes priority over a same-cycle fault set.
- Without the macro: sensor_fault is tied 0, fault_clr is unused, and there is no run counter.

Decomposition:
- Package `rain_pkg` holds:
  - 2-bit state typedef and encodings (DRY/WET_PEND/DRY_PEND/WET);
  - default confirm/divider constants.
- Sub-module `rain_tick_gen` holds the prescaler and enable gating, with outputs tick and count.
- The synchroniser and FSM stay in the top module.

Test Plan (CLK_DIV=4, WET_CONFIRM=3, DRY_CONFIRM=5, EVT_W=4):
- Raw held at 1 from reset release with enable = 1 → rain_sensor and rain_start rise together; the pulse is 1 clock; rain_events = 1.
- Wet for 2 ticks, then a 0 sample → stays DRY, no pulse, rain_events = 0. Repeat with 3 ticks → WET.
- From WET: 4 dry ticks, then a 1 sample → returns to WET with no rain_stop. Then 5 dry ticks → rain_stop pulse, rain_sensor = 0.
- 16 full rain cycles → rain_events saturates at 15; a 17th cycle keeps it at 15.
- enable dropped during WET_PEND → DRY next clock, prescaler count 0, outputs unchanged. rst_n pulsed low mid-WET → all outputs 0 immediately.
- With RAIN_FAULT_DET_EN and FAULT_SAMPLES = 8, raw stuck at 1 → sensor_fault = 1 after 8 wet ticks, rain_sensor = 0, no rain_stop. fault_clr → fault clears, FSM re-qualifies wet.
